// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: operator codes, flag bit indices, decode field widths.
// ALU_HALF_CARRY_EN adds the H flag bit to the flag vector.
package alu_defs_pkg;
  localparam logic [2:0] ALU_OP_NOP  = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_SUB  = 3'd2;
  localparam logic [2:0] ALU_OP_AND  = 3'd3;
  localparam logic [2:0] ALU_OP_OR   = 3'd4;
  localparam logic [2:0] ALU_OP_XOR  = 3'd5;
  localparam logic [2:0] ALU_OP_CP   = 3'd6;
  localparam logic [2:0] ALU_OP_PASS = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_H = 2;
`ifdef ALU_HALF_CARRY_EN
  localparam int FLAG_W = 3;
`else
  localparam int FLAG_W = 2;
`endif

  localparam int FIELD_X_W = 2;
  localparam int FIELD_Y_W = 3;
  localparam int FIELD_Z_W = 3;
  localparam int FIELD_P_W = 2;
  localparam int FIELD_Q_W = 1;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus next-state flag vector.
// H flag logic present only with ALU_HALF_CARRY_EN.
module alu_core
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        op,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags_next
);
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] zsrc;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result     = a;
    zsrc       = a;
    flags_next = '0;
    case (op)
      ALU_OP_ADD: begin
        result             = sum[WIDTH-1:0];
        zsrc               = result;
        flags_next[FLAG_C] = sum[WIDTH];
      end
      ALU_OP_SUB, ALU_OP_CP: begin
        // CP keeps a as the result but flags follow the subtraction
        result             = (op == ALU_OP_CP) ? a : diff[WIDTH-1:0];
        zsrc               = diff[WIDTH-1:0];
        flags_next[FLAG_C] = diff[WIDTH];
      end
      ALU_OP_AND:  begin result = a & b; zsrc = result; end
      ALU_OP_OR:   begin result = a | b; zsrc = result; end
      ALU_OP_XOR:  begin result = a ^ b; zsrc = result; end
      ALU_OP_PASS: begin result = b;     zsrc = result; end
      default:     begin result = a;     zsrc = result; end
    endcase
    flags_next[FLAG_Z] = (zsrc == '0);
`ifdef ALU_HALF_CARRY_EN
    case (op)
      ALU_OP_ADD:            flags_next[FLAG_H] = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'h0F;
      ALU_OP_SUB, ALU_OP_CP: flags_next[FLAG_H] = a[3:0] < b[3:0];
      ALU_OP_AND:            flags_next[FLAG_H] = 1'b1;
      default:               flags_next[FLAG_H] = 1'b0;
    endcase
`endif
  end
endmodule

// File: rtl/alu_decode_unit.sv
// Opcode field decoder (x/y/z/p/q) plus ALU with registered Z/C flags.
// ALU_HALF_CARRY_EN adds the registered H flag and its port.
module alu_decode_unit
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           insn,
  output logic [FIELD_X_W-1:0] insn_x,
  output logic [FIELD_Y_W-1:0] insn_y,
  output logic [FIELD_Z_W-1:0] insn_z,
  output logic [FIELD_P_W-1:0] insn_p,
  output logic [FIELD_Q_W-1:0] insn_q,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [2:0]           operator,
  output logic [WIDTH-1:0]     result,
`ifdef ALU_HALF_CARRY_EN
  output logic                 flag_half,
`endif
  output logic                 flag_zero,
  output logic                 flag_carry
);
  logic [FLAG_W-1:0] flags, flags_next;

  assign insn_x = insn[7:6];
  assign insn_y = insn[5:3];
  assign insn_z = insn[2:0];
  assign insn_p = insn[5:4];
  assign insn_q = insn[3];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a          (operand_a),
    .b          (operand_b),
    .op         (operator),
    .result     (result),
    .flags_next (flags_next)
  );

  // NOP leaves flags untouched so conditional jumps see the last real op
  always_ff @(posedge clk) begin
    if (!rst_n)                    flags <= '0;
    else if (operator != ALU_OP_NOP) flags <= flags_next;
  end

  assign flag_zero  = flags[FLAG_Z];
  assign flag_carry = flags[FLAG_C];
`ifdef ALU_HALF_CARRY_EN
  assign flag_half  = flags[FLAG_H];
`endif
endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed self-checking bench for alu_decode_unit (default and ALU_HALF_CARRY_EN builds).
module tb_alu_decode_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] insn;
  logic [1:0] insn_x;
  logic [2:0] insn_y, insn_z;
  logic [1:0] insn_p;
  logic       insn_q;
  logic [7:0] operand_a, operand_b, result;
  logic [2:0] operator;
  logic       flag_zero, flag_carry;
`ifdef ALU_HALF_CARRY_EN
  logic       flag_half;
`endif

  int errs   = 0;
  int checks = 0;

  alu_decode_unit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .insn       (insn),
    .insn_x     (insn_x),
    .insn_y     (insn_y),
    .insn_z     (insn_z),
    .insn_p     (insn_p),
    .insn_q     (insn_q),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .operator   (operator),
    .result     (result),
`ifdef ALU_HALF_CARRY_EN
    .flag_half  (flag_half),
`endif
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // h is only compared when the H flag exists
  task automatic chk_flags(input string tag, input logic z, input logic c, input logic h);
    chk({tag, ".z"}, flag_zero, z);
    chk({tag, ".c"}, flag_carry, c);
`ifdef ALU_HALF_CARRY_EN
    chk({tag, ".h"}, flag_half, h);
`else
    if (h === 1'bx) $display("bad h arg in %s", tag);
`endif
  endtask

  task automatic dec(input logic [7:0] i, input logic [1:0] x, input logic [2:0] y,
                     input logic [2:0] z, input logic [1:0] p, input logic q);
    insn = i;
    #1;
    chk($sformatf("dec%h.x", i), insn_x, x);
    chk($sformatf("dec%h.y", i), insn_y, y);
    chk($sformatf("dec%h.z", i), insn_z, z);
    chk($sformatf("dec%h.p", i), insn_p, p);
    chk($sformatf("dec%h.q", i), insn_q, q);
  endtask

  // apply op, check combinational result, clock, check flags
  task automatic alu(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] r,
                     input logic z, input logic c, input logic h);
    operator = op; operand_a = a; operand_b = b;
    #1;
    chk({tag, ".res"}, result, r);
    tick();
    chk_flags(tag, z, c, h);
  endtask

  initial begin
    rst_n = 1'b0; insn = 8'h00;
    operator = 3'd0; operand_a = 8'h00; operand_b = 8'h00;
    tick();
    tick();
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    dec(8'h06, 2'd0, 3'd0, 3'd6, 2'd0, 1'b0);
    dec(8'hC3, 2'd3, 3'd0, 3'd3, 2'd0, 1'b0);
    dec(8'h7E, 2'd1, 3'd7, 3'd6, 2'd3, 1'b1);

    alu("add05", 3'd1, 8'h05, 8'h01, 8'h06, 1'b0, 1'b0, 1'b0);
    alu("addFF", 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1);

    // NOP: result=a, flags hold over several clocks
    operator = 3'd0;
    #1;
    chk("nop.res", result, 8'hFF);
    repeat (3) tick();
    chk_flags("hold", 1'b1, 1'b1, 1'b1);

    alu("sub00", 3'd2, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
    alu("cp42",  3'd6, 8'h42, 8'h42, 8'h42, 1'b1, 1'b0, 1'b0);
    alu("cplt",  3'd6, 8'h10, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0);
    alu("and",   3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1);
    alu("or",    3'd4, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0);
    alu("xor",   3'd5, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);
    alu("pass",  3'd7, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    alu("add0F", 3'd1, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1);
    // repeated clock with same inputs re-registers identical flags
    tick();
    chk_flags("rerun", 1'b0, 1'b0, 1'b1);

    // reset wins over a flag-setting op; result stays live
    operator = 3'd1; operand_a = 8'hFF; operand_b = 8'h01; rst_n = 1'b0;
    #1;
    chk("rst.res", result, 8'h00);
    tick();
    chk_flags("rstmid", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_flags("postrst", 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
